// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared fetch-state enum and default widths for the fetch path
package isa_pkg;

    localparam int PC_W_DEF      = 10;
    localparam int RAS_DEPTH_DEF = 4;
    localparam int OPCODE_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module ret_stack
    import isa_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int W     = PC_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_idx;
    logic [PW:0]   count;

    // ptr names the next free slot, so the top of stack sits just below it
    assign top_idx = ptr - PW'(1);
    assign dout    = mem[top_idx];
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full) begin
                count <= count + (PW+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch FSM and next-pc mux; return stack present only with FETCH_RAS_EN
module fetch_unit
    import isa_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            jump,
    input  logic            taken,
    input  logic            call,
    input  logic            ret,
    input  logic            halt,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            done,
    output logic            ras_err
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc + PC_W'(1);
    assign done   = (state == HALT);

`ifdef FETCH_RAS_EN
    logic            push, pop, clear, err_set;
    logic            full, empty;
    logic [PC_W-1:0] top;

    ret_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (top),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) begin
            ras_err <= 1'b0;
        end else if (err_set) begin
            ras_err <= 1'b1;
        end
    end
`else
    assign ras_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
`ifdef FETCH_RAS_EN
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        err_set = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = '0;
`ifdef FETCH_RAS_EN
                    clear      = 1'b1;
`endif
                end
            end
            RUN: begin
                // ret outranks call, so a simultaneous call never pushes
                if (!stall) begin
                    if (halt) begin
                        state_next = HALT;
                    end else if (ret) begin
`ifdef FETCH_RAS_EN
                        if (!empty) begin
                            pop     = 1'b1;
                            pc_next = top;
                        end else begin
                            pc_next = pc_inc;
                            err_set = 1'b1;
                        end
`else
                        pc_next = pc_inc;
`endif
                    end else if (call) begin
                        pc_next = target;
`ifdef FETCH_RAS_EN
                        push    = 1'b1;
                        err_set = full;
`endif
                    end else if (jump && taken) begin
                        pc_next = target;
                    end else begin
                        pc_next = pc_inc;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
